mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one combinational unsigned array multiplier (Array_MUL_USign, N x M) between two requesters.
- Per requester: a valid/ready operand handshake and a valid/ready result handshake.
- Round-robin arbitration between the two requesters.
- Registers the operands and waits a fixed settle count before capturing the product. The long array carry chain therefore never sits on a single-cycle path.
- Sits between the lab's operand sources (e.g. two filter/accumulator datapaths) and the shared multiplier.

Parameters:
- N, 8, width of operand A.
- M, 8, width of operand B.
- SETTLE, 4, cycles the registered operands are held before the product is sampled. Legal range 1..15.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-high reset.
- req0_valid, input, 1, requester 0 presents operands.
- req0_ready, output, 1, requester 0 operands accepted this cycle.
- req0_a, input, N, requester 0 operand A.
- req0_b, input, M, requester 0 operand B.
- req1_valid, input, 1, requester 1 presents operands.
- req1_ready, output, 1, requester 1 operands accepted this cycle.
- req1_a, input, N, requester 1 operand A.
- req1_b, input, M, requester 1 operand B.
- resp0_valid, output, 1, product for requester 0 available.
- resp0_ready, input, 1, requester 0 takes the product.
- resp1_valid, output, 1, product for requester 1 available.
- resp1_ready, input, 1, requester 1 takes the product.
- resp_y, output, N+M, product, shared bus; meaningful only while a respX_valid is high.
- busy, output, 1, high in WAIT and DONE.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - all ready/valid outputs = 0, busy = 0, resp_y = 0.
  - operand registers = 0.
  - last_grant = 1, so requester 0 wins the first contest.
- FSM states: IDLE, WAIT, DONE.
- IDLE, grant (combinational):
  - only reqX_valid high -> grant X.
  - both high -> grant the one != last_grant.
  - reqX_ready = 1 only for the granted requester. Both readys are 0 in WAIT and DONE.
- IDLE -> WAIT on reqX_valid && reqX_ready (edge k):
  - capture a/b into operand registers; owner <= X; cnt <= SETTLE-1.
- WAIT:
  - multiplier inputs are driven solely from the operand registers.
  - cnt decrements each cycle.
  - at the edge where cnt == 0 (edge k+SETTLE): resp_y <= A*B; go to DONE.
- DONE:
  - resp<owner>_valid = 1; the other resp valid = 0; resp_y held stable.
  - on resp<owner>_ready: last_grant <= owner, resp_y is held (not cleared), go to IDLE.
  - resp_ready of the non-owner is ignored.
- Latency: accept at edge k -> respX_valid high in the cycle after edge k+SETTLE.
  - minimum issue interval SETTLE+2 cycles with resp_ready tied high.
- Arithmetic: unsigned, full N+M-bit product, no truncation or saturation.
  - (2^N-1)*(2^M-1) must be exact.
- Request-side rules:
  - requester operands are sampled only at the accept edge; later changes are ignored.
  - a requester dropping valid before it is granted is legal; nothing is lost.
- Simultaneous events:
  - a new request arriving in DONE waits; no bypass.
  - a request arriving in the same cycle the DONE handshake completes is granted in the following IDLE cycle using the updated last_grant.
- Reset mid-operation (any state): immediate return to reset values.
  - the in-flight product is discarded and no response is issued for it.
- Continuous valid from both requesters: grants strictly alternate 0,1,0,1...

Decomposition:
- Shared package (mul_share_pkg):
  - state encoding localparams S_IDLE=2'd0, S_WAIT=2'd1, S_DONE=2'd2.
  - counter width constant CNT_W=4.
- One sub-module: Array_MUL_USign #(.N(N),.M(M)), instantiated unchanged, fed from the operand registers.
- Arbiter, counter and FSM stay in mul_share_arbiter.

Test Plan:
- Single request: req0 a=12, b=13, resp0_ready=1 -> resp0_valid in the cycle after edge k+4, resp_y=156, resp1_valid never high.
- Contest after reset: both valid (req0 3*5, req1 7*9) -> req0 granted first, resp_y=15; then req1, resp_y=63; req1_ready=0 during the req0 operation.
- Fairness: both valid continuously for 6 operations -> grant order 0,1,0,1,0,1; each product equals its a*b.
- Backpressure: resp0_ready held low 10 cycles in DONE -> resp0_valid stays 1, resp_y stable, both readys 0; release -> IDLE next edge.
- Boundaries:
  - a=255, b=255 -> 65025.
  - a=0, b=200 -> 0.
  - a=1, b=255 -> 255.
- Reset in WAIT: assert rst mid-count -> outputs 0 immediately; after release a fresh req1 request is granted and no stale response appears.
- Random self-check: 50 random operands on random requesters -> every resp_y equals a*b of the matching accepted request.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and
// the width of the settle counter.
package mul_share_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/Array_MUL_USign.sv
// Combinational unsigned array multiplier: one shifted partial-product row
// per bit of b, accumulated down a chain of full-width adders.
module Array_MUL_USign #(
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] y
);

  logic [N+M-1:0] row_sum [0:M];

  assign row_sum[0] = '0;

  for (genvar j = 0; j < M; j++) begin : g_row
    logic [N+M-1:0] pp;
    assign pp             = (N+M)'(a & {N{b[j]}}) << j;
    assign row_sum[j + 1] = row_sum[j] + pp;
  end

  assign y = row_sum[M];

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one array multiplier between two requesters; the
// operands are registered and held SETTLE cycles before the product is taken.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 8,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [N-1:0]   req0_a,
  input  logic [M-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [N-1:0]   req1_a,
  input  logic [M-1:0]   req1_b,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [N+M-1:0] resp_y,
  output logic           busy
);

  state_t             state_q, state_d;
  logic               last_grant_q;
  logic               owner_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       op_a_q;
  logic [M-1:0]       op_b_q;
  logic [N+M-1:0]     resp_y_q;
  logic [N+M-1:0]     product;
  logic               grant_valid;
  logic               grant_id;
  logic               accept;
  logic               done_hs;

  Array_MUL_USign #(.N(N), .M(M)) u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .y (product)
  );

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  assign accept  = (state_q == ST_IDLE) && grant_valid;
  assign done_hs = (state_q == ST_DONE) && (owner_q ? resp1_ready : resp0_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;
        if (grant_valid) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        resp0_valid = !owner_q;
        resp1_valid = owner_q;
        if (done_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operands are frozen at the accept edge so the multiplier inputs stay
  // stable for the whole settle window; resp_y keeps its value after the hand-off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q       <= '0;
      op_b_q       <= '0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      resp_y_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (accept) begin
        op_a_q  <= grant_id ? req1_a : req0_a;
        op_b_q  <= grant_id ? req1_b : req0_b;
        owner_q <= grant_id;
        cnt_q   <= CNT_W'(SETTLE - 1);
      end
      if (state_q == ST_WAIT) begin
        if (cnt_q == '0) resp_y_q <= product;
        else             cnt_q    <= cnt_q - CNT_W'(1);
      end
      if (done_hs) last_grant_q <= owner_q;
    end
  end

  assign resp_y = resp_y_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomised scoreboard bench for mul_share_arbiter: accepted requests are
// queued with their expected product and deadline, a monitor checks responses.
module tb_mul_share_arbiter;

  localparam int N      = 8;
  localparam int M      = 8;
  localparam int SETTLE = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [N-1:0]   req0_a, req1_a;
  logic [M-1:0]   req0_b, req1_b;
  logic           resp0_valid, resp1_valid;
  logic           resp0_ready, resp1_ready;
  logic [N+M-1:0] resp_y;
  logic           busy;

  typedef struct {
    int     id;
    longint prod;
    longint k;
  } exp_t;

  exp_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  bit     model_busy = 0;
  bit     model_last = 1;
  bit     rand_done  = 0;

  mul_share_arbiter #(.N(N), .M(M), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_y      (resp_y),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Presents one operand pair on a requester and holds it until accepted.
  // Caller must be just after a rising edge.
  task automatic applyStimulus(input int id, input logic [N-1:0] a, input logic [M-1:0] b);
    bit got = 0;
    if (id == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else         begin req1_valid = 1; req1_a = a; req1_b = b; end
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (!rst && ((id == 0) ? req0_ready : req1_ready)) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("[TB] FAIL accept_timeout: requester %0d got no ready, expected one", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) begin
      req0_valid = 0; req0_a = N'($urandom); req0_b = M'($urandom);
    end else begin
      req1_valid = 0; req1_a = N'($urandom); req1_b = M'($urandom);
    end
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int t = 0; t < 2000 && !idle; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !model_busy) idle = 1;
    end
    if (!idle) begin
      errors++;
      checks++;
      $display("[TB] FAIL idle_timeout: %0d responses outstanding, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: a single shared unit, round-robin on ties, response exactly
  // SETTLE cycles after acceptance, product a*b in plain arithmetic.
  always @(negedge clk) begin
    if (!rst) begin
      bit exp_r0, exp_r1;
      exp_r0 = !model_busy && req0_valid && (!req1_valid || model_last == 1);
      exp_r1 = !model_busy && req1_valid && (!req0_valid || model_last == 0);
      checkOutput("req0_ready", req0_ready, exp_r0);
      checkOutput("req1_ready", req1_ready, exp_r1);
      checkOutput("busy", busy, model_busy);

      if (sb.size() == 0) begin
        checkOutput("resp0_valid_idle", resp0_valid, 0);
        checkOutput("resp1_valid_idle", resp1_valid, 0);
      end else if (cyc < sb[0].k + SETTLE) begin
        checkOutput("resp0_valid_early", resp0_valid, 0);
        checkOutput("resp1_valid_early", resp1_valid, 0);
      end else begin
        checkOutput("resp0_valid", resp0_valid, sb[0].id == 0);
        checkOutput("resp1_valid", resp1_valid, sb[0].id == 1);
        checkOutput("resp_y", resp_y, sb[0].prod);
        if ((sb[0].id == 0 && resp0_valid && resp0_ready) ||
            (sb[0].id == 1 && resp1_valid && resp1_ready)) begin
          model_last = sb[0].id[0];
          model_busy = 0;
          void'(sb.pop_front());
        end
      end

      if (req0_valid && req0_ready) begin
        sb.push_back('{0, longint'(req0_a) * longint'(req0_b), cyc + 1});
        model_busy = 1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back('{1, longint'(req1_a) * longint'(req1_b), cyc + 1});
        model_busy = 1;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    rst = 1;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    resp0_ready = 1; resp1_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_resp0_valid", resp0_valid, 0);
    checkOutput("reset_resp1_valid", resp1_valid, 0);
    checkOutput("reset_resp_y", resp_y, 0);
    rst = 0;

    $display("[TB] single request");
    applyStimulus(0, 8'd12, 8'd13);
    waitIdle();

    $display("[TB] contest after reset");
    fork
      applyStimulus(0, 8'd3, 8'd5);
      applyStimulus(1, 8'd7, 8'd9);
    join
    waitIdle();

    $display("[TB] fairness");
    fork
      begin
        for (int i = 0; i < 3; i++) applyStimulus(0, N'($urandom), M'($urandom));
      end
      begin
        for (int i = 0; i < 3; i++) applyStimulus(1, N'($urandom), M'($urandom));
      end
    join
    waitIdle();

    $display("[TB] backpressure");
    resp0_ready = 0;
    applyStimulus(0, 8'd100, 8'd3);
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(negedge clk);
      if (resp0_valid) got = 1;
    end
    checkOutput("bp_resp0_valid_seen", got, 1);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    resp0_ready = 1;
    waitIdle();

    $display("[TB] boundaries");
    applyStimulus(0, 8'd255, 8'd255);
    waitIdle();
    applyStimulus(1, 8'd0, 8'd200);
    waitIdle();
    applyStimulus(0, 8'd1, 8'd255);
    waitIdle();

    $display("[TB] reset during settle");
    applyStimulus(0, 8'd200, 8'd100);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_resp0_valid", resp0_valid, 0);
    checkOutput("rst_resp1_valid", resp1_valid, 0);
    checkOutput("rst_resp_y", resp_y, 0);
    sb.delete();
    model_busy = 0;
    model_last = 1;
    @(posedge clk);
    #1;
    rst = 0;
    applyStimulus(1, 8'd9, 8'd11);
    waitIdle();

    $display("[TB] random traffic");
    fork
      begin
        fork
          begin
            for (int i = 0; i < 25; i++) begin
              repeat ($urandom_range(0, 4)) @(posedge clk);
              #1;
              applyStimulus(0, N'($urandom), M'($urandom));
            end
          end
          begin
            for (int i = 0; i < 25; i++) begin
              repeat ($urandom_range(0, 4)) @(posedge clk);
              #1;
              applyStimulus(1, N'($urandom), M'($urandom));
            end
          end
        join
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          if (!rand_done) begin
            resp0_ready = 1'($urandom_range(0, 1));
            resp1_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    join
    resp0_ready = 1;
    resp1_ready = 1;
    waitIdle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
